// File: rtl/adder_sweep_checker.sv
// Exhaustive sweep checker for a WIDTH-bit adder under test.
// Drives every {a,b,cin} vector once and compares the DUT result DUT_LAT cycles later.
module adder_sweep_checker #(
    parameter int WIDTH   = 4,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             cin_out,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin
);

    localparam int VW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   vec;
    logic [2:0]      drain_cnt;
    logic            cmp_valid;
    logic [VW-1:0]   cmp_vec;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic            cmp_cin;
    logic [WIDTH:0]  exp_sum;
    logic            mismatch;
    logic            accept;

    // The index register doubles as the registered drive to the adder under test.
    assign {a_out, b_out, cin_out} = vec;

    assign busy   = (state == S_RUN) || (state == S_DRAIN);
    assign done   = (state == S_DONE);
    assign accept = (state == S_IDLE) && start;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            // The index holds at all-ones instead of wrapping so DRAIN keeps the last vector driven.
            S_RUN:   if (vec == '1) state_nxt = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == 3'(DUT_LAT - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
            else                  drain_cnt <= '0;
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_nodelay
            assign cmp_valid = (state == S_RUN);
            assign cmp_vec   = vec;
        end else begin : g_delay
            logic [DUT_LAT-1:0] dl_valid;
            logic [VW-1:0]      dl_vec [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_valid <= '0;
                end else begin
                    dl_valid[0] <= (state == S_RUN);
                    for (int i = 1; i < DUT_LAT; i++) dl_valid[i] <= dl_valid[i-1];
                end
            end

            // NOTE: the vector payload is not reset; only the valid bits gate its use.
            always_ff @(posedge clk) begin
                dl_vec[0] <= vec;
                for (int i = 1; i < DUT_LAT; i++) dl_vec[i] <= dl_vec[i-1];
            end

            assign cmp_valid = dl_valid[DUT_LAT-1];
            assign cmp_vec   = dl_vec[DUT_LAT-1];
        end
    endgenerate

    assign {cmp_a, cmp_b, cmp_cin} = cmp_vec;
    assign exp_sum  = {1'b0, cmp_a} + {1'b0, cmp_b} + {{WIDTH{1'b0}}, cmp_cin};
    assign mismatch = cmp_valid && ({dut_cout, dut_sum} != exp_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
        end else if (accept) begin
            vec             <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
        end else begin
            if (state == S_RUN && vec != '1) vec <= vec + 1'b1;
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= cmp_a;
                    first_err_b     <= cmp_b;
                    first_err_cin   <= cmp_cin;
                end
            end
            // The final comparison lands on the same edge that enters DONE.
            if (state_nxt == S_DONE) pass <= (err_count == '0) && !mismatch;
        end
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: three instances (latency 0, 1, 2) against a fault-injected adder,
// checked against an exhaustive arithmetic model of the sweep.
module tb_adder_sweep_checker;

    localparam int W  = 4;
    localparam int NV = 1 << (2 * W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [W-1:0] a_o [3];
    logic [W-1:0] b_o [3];
    logic         cin_o [3];
    logic [W-1:0] sum_i [3];
    logic         cout_i [3];
    logic         busy [3];
    logic         done [3];
    logic         pass [3];
    logic         fev [3];
    logic [W-1:0] fea [3];
    logic [W-1:0] feb [3];
    logic         fec [3];
    logic [15:0]  err0;
    logic [15:0]  err1;
    logic [3:0]   err2;

    // Per-vector XOR applied to the ideal sum; zero means the adder is correct for that vector.
    logic [W:0] xr [NV];

    logic [W:0] r0, r1, r2, p1a, p1b, p2a, p2b;

    assign r0 = ({1'b0, a_o[0]} + {1'b0, b_o[0]} + {{W{1'b0}}, cin_o[0]}) ^ xr[{a_o[0], b_o[0], cin_o[0]}];
    assign r1 = ({1'b0, a_o[1]} + {1'b0, b_o[1]} + {{W{1'b0}}, cin_o[1]}) ^ xr[{a_o[1], b_o[1], cin_o[1]}];
    assign r2 = ({1'b0, a_o[2]} + {1'b0, b_o[2]} + {{W{1'b0}}, cin_o[2]}) ^ xr[{a_o[2], b_o[2], cin_o[2]}];

    always @(posedge clk) begin
        p1a <= r1;
        p1b <= p1a;
        p2a <= r2;
        p2b <= p2a;
    end

    assign {cout_i[0], sum_i[0]} = r0;
    assign {cout_i[1], sum_i[1]} = p1b;
    assign {cout_i[2], sum_i[2]} = p2b;

    adder_sweep_checker #(.WIDTH(W), .DUT_LAT(0), .ERR_W(16)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[0]), .b_out(b_o[0]), .cin_out(cin_o[0]),
        .dut_sum(sum_i[0]), .dut_cout(cout_i[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0),
        .first_err_valid(fev[0]), .first_err_a(fea[0]), .first_err_b(feb[0]), .first_err_cin(fec[0])
    );

    adder_sweep_checker #(.WIDTH(W), .DUT_LAT(1), .ERR_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[1]), .b_out(b_o[1]), .cin_out(cin_o[1]),
        .dut_sum(sum_i[1]), .dut_cout(cout_i[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1),
        .first_err_valid(fev[1]), .first_err_a(fea[1]), .first_err_b(feb[1]), .first_err_cin(fec[1])
    );

    adder_sweep_checker #(.WIDTH(W), .DUT_LAT(2), .ERR_W(4)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[2]), .b_out(b_o[2]), .cin_out(cin_o[2]),
        .dut_sum(sum_i[2]), .dut_cout(cout_i[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2),
        .first_err_valid(fev[2]), .first_err_a(fea[2]), .first_err_b(feb[2]), .first_err_cin(fec[2])
    );

    int   busy_cyc [3] = '{0, 0, 0};
    int   done_cnt [3] = '{0, 0, 0};
    logic pass_at_done [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy[i] === 1'b1) busy_cyc[i]++;
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                pass_at_done[i] = pass[i];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_faults(input int mode);
        for (int v = 0; v < NV; v++) begin
            int a, b, c, s;
            a = v >> (W + 1);
            b = (v >> 1) & ((1 << W) - 1);
            c = v & 1;
            s = a + b + c;
            case (mode)
                1:       xr[v] = (W + 1)'(s & 1);                    // sum bit 0 stuck at 0
                2:       xr[v] = (W + 1)'(~s & (1 << W));            // carry-out stuck at 1
                3:       xr[v] = ($urandom_range(0, 9) == 0) ? (W + 1)'($urandom_range(1, 31)) : '0;
                4:       xr[v] = (v == NV - 1) ? (W + 1)'($urandom_range(1, 31)) : '0;
                5:       xr[v] = (v == 0) ? (W + 1)'($urandom_range(1, 31)) : '0;
                default: xr[v] = '0;
            endcase
        end
    endtask

    // Walk every vector in sweep order and compare the faulty adder against a+b+cin.
    task automatic model(output int n, output int first);
        n     = 0;
        first = -1;
        for (int v = 0; v < NV; v++) begin
            int a, b, c, ideal, actual;
            a      = v >> (W + 1);
            b      = (v >> 1) & ((1 << W) - 1);
            c      = v & 1;
            ideal  = a + b + c;
            actual = ideal ^ int'(xr[v]);
            if (actual != ideal) begin
                n++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_outs%0d", tag, i),
                  {a_o[i], b_o[i], cin_o[i], busy[i], done[i], pass[i], fev[i], fea[i], feb[i], fec[i]}, 0);
        check({tag, "_err0"}, 32'(err0), 0);
        check({tag, "_err1"}, 32'(err1), 0);
        check({tag, "_err2"}, 32'(err2), 0);
    endtask

    task automatic run_sweep(input int mode, input bit poke);
        int n, first, cyc;
        int b0 [3];
        int d0 [3];
        int ea, eb, ec;
        string t;
        t = $sformatf("m%0d", mode);
        fill_faults(mode);
        model(n, first);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b0[i] = busy_cyc[i];
            d0[i] = done_cnt[i];
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({t, "_vec0"}, {a_o[0], b_o[0], cin_o[0], busy[0]}, 1);
        cyc = 0;
        while (done[2] !== 1'b1 && cyc < 2000) begin
            start = poke && (cyc == 10 || cyc == 300 || done[0] === 1'b1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({t, "_no_timeout"}, 32'(cyc < 2000), 1);
        repeat (3) @(negedge clk);

        ea = (n > 0) ? (first >> (W + 1)) : 0;
        eb = (n > 0) ? ((first >> 1) & ((1 << W) - 1)) : 0;
        ec = (n > 0) ? (first & 1) : 0;

        check({t, "_busy0"}, busy_cyc[0] - b0[0], NV);
        check({t, "_busy1"}, busy_cyc[1] - b0[1], NV + 1);
        check({t, "_busy2"}, busy_cyc[2] - b0[2], NV + 2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_done_cnt%0d", t, i), done_cnt[i] - d0[i], 1);
            check($sformatf("%s_done_low%0d", t, i), {busy[i], done[i]}, 0);
        end
        check({t, "_pass_done0"}, 32'(pass_at_done[0]), 32'(n == 0));
        check({t, "_pass_done2"}, 32'(pass_at_done[2]), 32'(n == 0));
        check({t, "_pass_hold0"}, 32'(pass[0]), 32'(n == 0));
        check({t, "_pass_hold2"}, 32'(pass[2]), 32'(n == 0));
        check({t, "_err0"}, 32'(err0), (n > 65535) ? 65535 : n);
        check({t, "_err2"}, 32'(err2), (n > 15) ? 15 : n);
        check({t, "_first0"}, {fev[0], fea[0], feb[0], fec[0]}, {n > 0, W'(ea), W'(eb), ec[0]});
        check({t, "_first2"}, {fev[2], fea[2], feb[2], fec[2]}, {n > 0, W'(ea), W'(eb), ec[0]});
        if (mode == 0) begin
            check({t, "_lat1_pass"}, 32'(pass[1]), 0);
            check({t, "_lat1_err_nz"}, 32'(err1 != 0), 1);
        end
    endtask

    initial begin
        #1;
        check_all_zero("por");
        fill_faults(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("idle");

        run_sweep(0, 1'b1);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);
        run_sweep(4, 1'b0);
        run_sweep(5, 1'b0);
        run_sweep(3, 1'b1);

        begin
            int d0 [3];
            for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
            fill_faults(0);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (100) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check_all_zero("midrst");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (600) @(negedge clk);
            for (int i = 0; i < 3; i++)
                check($sformatf("midrst_no_done%0d", i), done_cnt[i] - d0[i], 0);
            check_all_zero("midrst_idle");
        end

        run_sweep(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_sweep_checker.md
ADDER_SWEEP_CHECKER -- requirements
Module: adder_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width of adder under test (1..12).
REQ-002 SHALL have parameter DUT_LAT, default 0, adder-under-test latency in clock cycles (0..7).
REQ-003 SHALL have parameter ERR_W, default 16, error counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have ports a_out, b_out  output  WIDTH each  operands driven to the adder under test.
REQ-008 SHALL have port cin_out  output  1  carry-in driven to the adder under test.
REQ-009 SHALL have ports dut_sum  input  WIDTH, dut_cout  input  1  adder-under-test result.
REQ-010 SHALL have ports busy, done, pass  output  1 each  sweep status.
REQ-011 SHALL have port err_count  output  ERR_W  mismatching vectors in current/last sweep.
REQ-012 SHALL have ports first_err_valid  output 1, first_err_a, first_err_b  output WIDTH, first_err_cin  output 1  first failing vector.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE; DRAIN skipped when DUT_LAT=0.
REQ-014 IDLE: start=1 SHALL enter RUN next cycle, clear err_count, pass, first_err_* and set vector index to 0.
REQ-015 Vector index SHALL be a (2*WIDTH+1)-bit counter {a,b,cin}: cin innermost, b middle, a outermost; a_out/b_out/cin_out registered from it.
REQ-016 RUN SHALL last exactly 2^(2*WIDTH+1) cycles, index +1 per cycle, leaving RUN on wrap of index from all-ones.
REQ-017 DRAIN SHALL last exactly DUT_LAT cycles with drive outputs held at last vector.
REQ-018 Expected result SHALL be full (WIDTH+1)-bit a+b+cin; compared against {dut_cout,dut_sum}.
REQ-019 Each vector SHALL be compared exactly once, DUT_LAT cycles after it is driven (DUT_LAT=0: same cycle it is driven), using a DUT_LAT-deep delay line of vector and valid bit.
REQ-020 Mismatch SHALL increment err_count, saturating at 2^ERR_W-1.
REQ-021 First mismatch of a sweep SHALL latch first_err_a/b/cin and set first_err_valid; later mismatches SHALL not overwrite.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-023 DONE SHALL last one cycle: done=1 for that cycle only; pass SHALL become 1 there iff err_count=0 and hold until next accepted start.
REQ-024 start while not IDLE SHALL be ignored; start in DONE cycle SHALL be ignored.
REQ-025 err_count, first_err_* SHALL hold after DONE until next accepted start.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (a_out, b_out, cin_out, busy, done, pass, err_count, first_err_*), and clear delay line valids.
REQ-027 Reset mid-sweep SHALL abandon the sweep; no done pulse SHALL follow; next start begins from index 0.

Verification
REQ-028 WIDTH=4, DUT_LAT=0, ideal combinational adder, start pulse -> busy for 512 cycles, done one cycle, pass=1, err_count=0, first_err_valid=0.
REQ-029 WIDTH=4, DUT_LAT=0, dut_sum[0] stuck at 0 -> err_count=256, pass=0, first_err a=0 b=0 cin=1.
REQ-030 WIDTH=4, DUT_LAT=2, ideal adder registered twice -> busy 514 cycles, pass=1; same DUT with DUT_LAT=1 -> pass=0, err_count nonzero.
REQ-031 WIDTH=4, ERR_W=4, dut_cout stuck at 1 -> err_count saturates at 15, pass=0.
REQ-032 rst_n low at cycle 100 of RUN -> all outputs 0 at once, no done; restart -> full 512-cycle clean sweep, pass=1.
REQ-033 start pulses at cycles 10 and 300 of RUN and in DONE cycle -> ignored; exactly one done per accepted start.
